mult_share_arbiter: RTL and testbench
=====================================

// Module: mult_share_arbiter
// PURPOSE
//  Shares one 16x16 unsigned array multiplier (arraymultiplier, combinational) among NREQ requesters.
//  Round-robin arbitration, valid/ready request and response handshakes, operand/result registers.
//  SETTLE wait cycles are counted so the multiplier ripple path is treated as a multicycle path.
//  Sits between requesting datapath blocks and the multiplier; one operation in flight at a time.
// PARAMETERS
//  NREQ    4   number of requesters (2..8)
//  IDW     2   width of requester id, = ceil(log2(NREQ)), min 1
//  SETTLE  2   clock cycles allowed for multiplier settling (>=1)
// PORTS
//  clk           in   1          rising-edge clock
//  rst           in   1          asynchronous reset, active-high
//  req_valid     in   NREQ       per-requester request valid
//  req_a         in   NREQ*16    operand A; requester i at [16*i+15:16*i]
//  req_b         in   NREQ*16    operand B; same packing as req_a
//  req_ready     out  NREQ       one-hot grant; request i accepted on edge where valid[i]&ready[i]
//  resp_valid    out  1          result valid
//  resp_id       out  IDW        index of requester that owns the result
//  resp_product  out  32         unsigned A*B
//  resp_ready    in   1          consumer accepts result on edge where resp_valid&resp_ready
//  busy          out  1          high in any state other than IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE, last_grant=NREQ-1, cnt=0, op regs=0, resp_valid=0, resp_id=0,
//   resp_product=0, req_ready=0, busy=0. Reset mid-operation drops the op; no response issued.
//  States: IDLE -> CALC -> RESP -> IDLE.
//  IDLE: if any req_valid, grant g = first set req_valid scanning last_grant+1, +2, ... mod NREQ.
//   req_ready = one-hot(g), combinational from req_valid and last_grant, only in IDLE.
//   On that edge: op_a<=req_a[g], op_b<=req_b[g], op_id<=g, last_grant<=g, cnt<=SETTLE-1, ->CALC.
//   No req_valid: stay IDLE, req_ready=0.
//  CALC: multiplier driven only from op_a/op_b registers. cnt!=0: cnt<=cnt-1.
//   cnt==0: resp_product<=multiplier output, resp_id<=op_id, resp_valid<=1, ->RESP.
//  RESP: resp_valid, resp_id and resp_product held stable until resp_ready is sampled high.
//   On handshake edge: resp_valid<=0, ->IDLE. resp_product/resp_id keep their last value.
//  Latency: resp_valid rises exactly SETTLE edges after the accept edge, and stays high
//   while resp_ready=0.
//  Throughput: one op per SETTLE+2 cycles with resp_ready tied high. No request is accepted
//   in CALC or RESP; req_ready=0 there regardless of req_valid.
//  Requesters hold valid/operands until accepted. Operands are sampled only on the accept edge.
//   Later changes do not affect the result.
//  Dropping req_valid before acceptance withdraws the request; no state change.
//  Fairness: a continuously requesting port waits at most NREQ-1 other grants.
//  Pointer wraps NREQ-1 -> 0. Only the accepted port advances last_grant.
//  Arithmetic: unsigned; full 32-bit product, no truncation or overflow flag.
//  resp_ready while resp_valid=0 is ignored.
// TESTING
//  1 After reset, req_valid=0001, a0=3, b0=5 -> req_ready=0001 same cycle;
//    SETTLE=2 edges later resp_valid=1, id=0, product=15.
//  2 req_valid=1111 held continuously, resp_ready=1 -> grant order 0,1,2,3,0,
//    each grant SETTLE+2=4 cycles apart.
//  3 a=FFFF, b=FFFF on port 2 -> product=FFFE0001, id=2. a=0, b=1234 -> product=0.
//  4 resp_ready=0 for 5 cycles in RESP -> resp_valid/id/product stable;
//    req_valid=1111 gives req_ready=0 throughout; accept occurs 1 cycle after resp handshake.
//  5 Port 1 changes a/b the cycle after acceptance -> result equals the captured operands only.
//  6 Assert rst during CALC -> all outputs reset immediately (async);
//    no resp_valid; next grant goes to port 0 first.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// Time-shares one combinational 16x16 array multiplier among NREQ requesters using
// round-robin arbitration. The ripple path gets SETTLE counted cycles before its result is captured.

module arraymultiplier (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);

  // Each row adds a & b[i] into the running sum shifted down one place.
  // The bit that drops out of the LSB is product bit i.
  always_comb begin
    logic [16:0] acc;
    logic [15:0] pp;
    logic        carry;
    logic        s;
    p     = '0;
    pp    = '0;
    carry = 1'b0;
    s     = 1'b0;
    acc   = {1'b0, a & {16{b[0]}}};
    p[0]  = acc[0];
    for (int i = 1; i < 16; i++) begin
      pp    = a & {16{b[i]}};
      carry = 1'b0;
      for (int j = 0; j < 16; j++) begin
        s      = acc[j+1] ^ pp[j] ^ carry;
        carry  = (acc[j+1] & pp[j]) | (carry & (acc[j+1] ^ pp[j]));
        acc[j] = s;
      end
      acc[16] = carry;
      p[i]    = acc[0];
    end
    p[31:16] = acc[16:1];
  end

endmodule

module mult_share_arbiter #(
  parameter int NREQ   = 4,
  parameter int IDW    = 2,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*16-1:0] req_a,
  input  logic [NREQ*16-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              resp_valid,
  output logic [IDW-1:0]    resp_id,
  output logic [31:0]       resp_product,
  input  logic              resp_ready,
  output logic              busy
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t         state;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] op_id;
  logic [IDW-1:0] grant_id;
  logic [CW-1:0]  cnt;
  logic [15:0]    op_a;
  logic [15:0]    op_b;
  logic [15:0]    sel_a;
  logic [15:0]    sel_b;
  logic           grant_found;
  logic [31:0]    mult_p;

  // Scan forward from the port after the last winner; the first valid port wins.
  always_comb begin
    logic [IDW:0] pos;
    grant_found = 1'b0;
    grant_id    = '0;
    sel_a       = '0;
    sel_b       = '0;
    pos         = '0;
    for (int k = 1; k <= NREQ; k++) begin
      pos = {1'b0, last_grant} + (IDW+1)'(k);
      if (pos >= (IDW+1)'(NREQ))
        pos = pos - (IDW+1)'(NREQ);
      if (!grant_found && req_valid[pos[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = pos[IDW-1:0];
        sel_a       = req_a[{pos[IDW-1:0], 4'b0000} +: 16];
        sel_b       = req_b[{pos[IDW-1:0], 4'b0000} +: 16];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_found)
      req_ready = NREQ'(1) << grant_id;
  end

  arraymultiplier u_mult (
    .a (op_a),
    .b (op_b),
    .p (mult_p)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= IDW'(NREQ - 1);
      cnt          <= '0;
      op_a         <= '0;
      op_b         <= '0;
      op_id        <= '0;
      resp_valid   <= 1'b0;
      resp_id      <= '0;
      resp_product <= '0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            op_a       <= sel_a;
            op_b       <= sel_b;
            op_id      <= grant_id;
            last_grant <= grant_id;
            cnt        <= CW'(SETTLE - 1);
            state      <= CALC;
            busy       <= 1'b1;
          end
        end
        CALC: begin
          // The multiplier output is only trusted once the settle count has run out.
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            resp_product <= mult_p;
            resp_id      <= op_id;
            resp_valid   <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
            busy       <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Testbench for mult_share_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of grants, latency and products.

module tb_mult_share_arbiter;

  localparam int NREQ   = 4;
  localparam int IDW    = 2;
  localparam int SETTLE = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*16-1:0] req_a = '0;
  logic [NREQ*16-1:0] req_b = '0;
  logic [NREQ-1:0]    req_ready;
  logic               resp_valid;
  logic [IDW-1:0]     resp_id;
  logic [31:0]        resp_product;
  logic               resp_ready = 1'b0;
  logic               busy;

  mult_share_arbiter #(.NREQ(NREQ), .IDW(IDW), .SETTLE(SETTLE)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_id      (resp_id),
    .resp_product (resp_product),
    .resp_ready   (resp_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Transaction-level reference: one op in flight, visible SETTLE edges after acceptance.
  bit          m_inflight   = 1'b0;
  int          m_accept_at  = 0;
  int          m_edges      = 0;
  int          m_last       = NREQ - 1;
  int          m_op_id      = 0;
  logic [31:0] m_op_prod    = '0;
  int          m_shown_id   = 0;
  logic [31:0] m_shown_prod = '0;

  typedef struct {
    int at;
    int id;
  } grant_t;
  grant_t grant_log[$];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic int modelGrant(input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      int p;
      p = (m_last + k) % NREQ;
      if (v[p]) return p;
    end
    return -1;
  endfunction

  function automatic logic [NREQ*16-1:0] randLanes();
    logic [NREQ*16-1:0] r;
    r = '0;
    for (int i = 0; i < NREQ; i++) begin
      case ($urandom_range(5))
        0:       r[16*i +: 16] = 16'h0000;
        1:       r[16*i +: 16] = 16'hFFFF;
        default: r[16*i +: 16] = 16'($urandom);
      endcase
    end
    return r;
  endfunction

  // One clock cycle: drive, compare against the model, clock, advance the model.
  task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [NREQ*16-1:0] a,
                               input logic [NREQ*16-1:0] b, input logic rr);
    int              g;
    bit              vis;
    logic [NREQ-1:0] exp_ready;
    @(negedge clk);
    req_valid  = v;
    req_a      = a;
    req_b      = b;
    resp_ready = rr;
    #1;
    vis = m_inflight && (m_edges >= m_accept_at + SETTLE);
    g   = m_inflight ? -1 : modelGrant(v);
    exp_ready = (g >= 0) ? (NREQ'(1) << g) : '0;
    if (vis) begin
      m_shown_id   = m_op_id;
      m_shown_prod = m_op_prod;
    end
    checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
    checkOutput("busy", 32'(busy), 32'(m_inflight));
    checkOutput("resp_valid", 32'(resp_valid), 32'(vis));
    checkOutput("resp_id", 32'(resp_id), 32'(m_shown_id));
    checkOutput("resp_product", resp_product, m_shown_prod);
    for (int i = 0; i < NREQ; i++)
      if (req_ready[i]) grant_log.push_back('{at: m_edges, id: i});
    @(posedge clk);
    m_edges++;
    if (g >= 0) begin
      m_inflight  = 1'b1;
      m_accept_at = m_edges;
      m_last      = g;
      m_op_id     = g;
      m_op_prod   = 32'(a[16*g +: 16]) * 32'(b[16*g +: 16]);
    end else if (vis && rr) begin
      m_inflight = 1'b0;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    req_valid  = '0;
    resp_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("rst_resp_id", 32'(resp_id), 32'h0);
    checkOutput("rst_resp_product", resp_product, 32'h0);
    @(negedge clk);
    rst          = 1'b0;
    m_inflight   = 1'b0;
    m_last       = NREQ - 1;
    m_shown_id   = 0;
    m_shown_prod = '0;
  endtask

  // Single-port op from IDLE; operands are scrambled right after the accept edge.
  task automatic directedOp(input string tag, input int port, input logic [15:0] a,
                            input logic [15:0] b, input logic [31:0] exp_prod,
                            input int stall, input logic [NREQ-1:0] bg);
    logic [NREQ*16-1:0] pa;
    logic [NREQ*16-1:0] pb;
    pa = randLanes();
    pb = randLanes();
    pa[16*port +: 16] = a;
    pb[16*port +: 16] = b;
    applyStimulus(NREQ'(1) << port, pa, pb, 1'b0);
    repeat (SETTLE) applyStimulus(bg, randLanes(), randLanes(), 1'b0);
    #1;
    checkOutput({tag, "_valid"}, 32'(resp_valid), 32'h1);
    checkOutput({tag, "_id"}, 32'(resp_id), 32'(port));
    checkOutput({tag, "_product"}, resp_product, exp_prod);
    repeat (stall) applyStimulus(bg, randLanes(), randLanes(), 1'b0);
    applyStimulus(bg, randLanes(), randLanes(), 1'b1);
  endtask

  initial begin
    logic [NREQ-1:0]    cur_v;
    logic [NREQ*16-1:0] cur_a;
    logic [NREQ*16-1:0] cur_b;

    doReset();

    directedOp("t1", 0, 16'd3, 16'd5, 32'd15, 0, '0);
    directedOp("t3_max", 2, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0, '0);
    directedOp("t3_zero", 3, 16'h0000, 16'h1234, 32'h0, 0, '0);
    directedOp("t5", 1, 16'd7, 16'd9, 32'd63, 0, '0);
    directedOp("t4", 2, 16'd100, 16'd200, 32'd20000, 5, '1);

    // Accept one op, then reset while it is still settling.
    applyStimulus('1, randLanes(), randLanes(), 1'b0);
    doReset();

    grant_log.delete();
    repeat (20) applyStimulus('1, randLanes(), randLanes(), 1'b1);
    checkOutput("t2_count", 32'(grant_log.size() >= 5), 32'h1);
    if (grant_log.size() >= 5) begin
      for (int i = 0; i < 5; i++)
        checkOutput($sformatf("t2_order%0d", i), 32'(grant_log[i].id), 32'(i % NREQ));
      for (int i = 0; i < 4; i++)
        checkOutput($sformatf("t2_gap%0d", i), 32'(grant_log[i+1].at - grant_log[i].at),
                    32'(SETTLE + 2));
    end

    cur_v = '0;
    cur_a = randLanes();
    cur_b = randLanes();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(3) == 0) cur_v = NREQ'($urandom);
      if ($urandom_range(3) == 0) cur_a = randLanes();
      if ($urandom_range(3) == 0) cur_b = randLanes();
      applyStimulus(cur_v, cur_a, cur_b, 1'($urandom_range(1)));
      if (c == 700) doReset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
